// File: rtl/fpadd_accum_ctrl_pkg.sv
// Shared constants for the floating-point accumulation controller.
// Contents: default word width, controller state encoding, adder op codes.
package fpadd_accum_ctrl_pkg;

  localparam int unsigned FP_WIDTH = 32;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StCapt = 2'd2,
    StDone = 2'd3
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/fpadd_accum_fsm.sv
// Sequencing for the accumulation controller: state register, adder latency
// down-counter, first/last element flags and handshake decode.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   s_valid, s_last   input element handshake / end-of-vector marker
//   m_ready           consumer accepts the result
//   s_ready           element can be accepted (IDLE only, low during reset)
//   m_valid           result valid (DONE)
//   add_ce            adder clock enable (EXEC only)
//   load_first        first element of a vector is being accepted
//   load_elem         a later element is being accepted; adder operands load
//   capt              adder sum is valid and must be captured
module fpadd_accum_fsm
  import fpadd_accum_ctrl_pkg::*;
#(
  parameter int unsigned LATENCY = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic s_valid,
  input  logic s_last,
  input  logic m_ready,
  output logic s_ready,
  output logic m_valid,
  output logic add_ce,
  output logic load_first,
  output logic load_elem,
  output logic capt
);

  localparam int unsigned LatW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [LatW-1:0] LatLast = LatW'(LATENCY - 1);

  state_e          state_q, state_d;
  logic [LatW-1:0] cnt_q, cnt_d;
  logic            first_q, first_d;
  logic            last_q, last_d;
  logic            beat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      first_q <= 1'b1;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    first_d    = first_q;
    last_d     = last_q;
    s_ready    = 1'b0;
    m_valid    = 1'b0;
    add_ce     = 1'b0;
    load_first = 1'b0;
    load_elem  = 1'b0;
    capt       = 1'b0;
    beat       = 1'b0;
    unique case (state_q)
      StIdle: begin
        s_ready = ~rst;
        beat    = s_valid & ~rst;
        if (beat) begin
          if (first_q) begin
            // First element only seeds the accumulator; no adder pass needed.
            load_first = 1'b1;
            first_d    = 1'b0;
            if (s_last) state_d = StDone;
          end else begin
            load_elem = 1'b1;
            last_d    = s_last;
            cnt_d     = LatLast;
            state_d   = StExec;
          end
        end
      end
      StExec: begin
        add_ce = 1'b1;
        if (cnt_q == '0) state_d = StCapt;
        else             cnt_d   = cnt_q - LatW'(1);
      end
      StCapt: begin
        capt    = 1'b1;
        state_d = last_q ? StDone : StIdle;
      end
      StDone: begin
        m_valid = 1'b1;
        if (m_ready) begin
          first_d = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: rtl/fpadd_accum_ctrl.sv
// Initiator-side controller for a registered floating-point adder. Reduces each
// s_last-delimited vector to one value by serial accumulation (sum, or first
// minus all later elements) and returns the result with its element count.
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   s_valid/s_ready/s_data     input element stream, s_last ends a vector,
//   s_last/s_mode              s_mode (0 sum, 1 difference) taken on first beat
//   m_valid/m_ready            result handshake
//   m_data/m_count             reduced value and saturating element count
//   add_a/add_b/add_op/add_ce  adder operand, op and clock-enable drive
//   add_z                      adder registered result
module fpadd_accum_ctrl
  import fpadd_accum_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH   = FP_WIDTH,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_last,
  input  logic             s_mode,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [CNT_W-1:0] m_count,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_op,
  output logic             add_ce,
  input  logic [WIDTH-1:0] add_z
);

  logic             load_first, load_elem, capt;
  logic [WIDTH-1:0] acc_q, add_a_q, add_b_q;
  logic [CNT_W-1:0] count_q;
  logic             mode_q, add_op_q;

  fpadd_accum_fsm #(
    .LATENCY (LATENCY)
  ) u_fsm (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_last     (s_last),
    .m_ready    (m_ready),
    .s_ready    (s_ready),
    .m_valid    (m_valid),
    .add_ce     (add_ce),
    .load_first (load_first),
    .load_elem  (load_elem),
    .capt       (capt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q    <= '0;
      mode_q   <= OP_ADD;
      count_q  <= '0;
      add_a_q  <= '0;
      add_b_q  <= '0;
      add_op_q <= OP_ADD;
    end else begin
      if (load_first) begin
        acc_q   <= s_data;
        mode_q  <= s_mode;
        count_q <= CNT_W'(1);
      end else if (load_elem) begin
        add_a_q  <= acc_q;
        add_b_q  <= s_data;
        add_op_q <= mode_q ? OP_SUB : OP_ADD;
        // Count sticks at all-ones; the accumulation itself carries on.
        if (!(&count_q)) count_q <= count_q + CNT_W'(1);
      end else if (capt) begin
        acc_q <= add_z;
      end
    end
  end

  // acc/count are frozen while DONE, so the result stays stable under backpressure.
  assign m_data  = acc_q;
  assign m_count = count_q;
  assign add_a   = add_a_q;
  assign add_b   = add_b_q;
  assign add_op  = add_op_q;

endmodule

// File: tb/tb_fpadd_accum_ctrl.sv
module tb_fpadd_accum_ctrl;

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0, s_last = 1'b0, s_mode = 1'b0, m_ready = 1'b0;
  logic [W-1:0]  s_data = '0;
  logic          s_ready, m_valid, add_op, add_ce;
  logic [W-1:0]  m_data, add_a, add_b, add_z;
  logic [CW-1:0] m_count;

  int checks = 0;
  int errors = 0;
  int ce_cycles = 0;
  int ce_op1 = 0;

  always #5 clk = ~clk;

  fpadd_accum_ctrl #(
    .WIDTH   (W),
    .LATENCY (2),
    .CNT_W   (CW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .s_mode  (s_mode),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_count (m_count),
    .add_a   (add_a),
    .add_b   (add_b),
    .add_op  (add_op),
    .add_ce  (add_ce),
    .add_z   (add_z)
  );

  function automatic real sp2r(input logic [31:0] x);
    logic [63:0] d;
    logic [10:0] e;
    if (x[30:0] == 31'd0) begin
      d = {x[31], 63'd0};
    end else begin
      e = {3'd0, x[30:23]} + 11'd896;
      d = {x[31], e, x[22:0], 29'd0};
    end
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2sp(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  // Registered adder: operands captured on one enabled edge, sum on the next.
  logic [W-1:0] ra, rb;
  logic         rop;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ra <= '0; rb <= '0; rop <= 1'b0; add_z <= '0;
    end else if (add_ce) begin
      ra    <= add_a;
      rb    <= add_b;
      rop   <= add_op;
      add_z <= r2sp(rop ? sp2r(ra) - sp2r(rb) : sp2r(ra) + sp2r(rb));
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference reduction straight from the arithmetic definition.
  function automatic logic [31:0] ref_reduce(input logic [31:0] v[$], input logic mode);
    real acc;
    if (v.size() == 1) return v[0];
    acc = sp2r(v[0]);
    for (int i = 1; i < v.size(); i++) acc = mode ? acc - sp2r(v[i]) : acc + sp2r(v[i]);
    return r2sp(acc);
  endfunction

  // Operands must hold for every enabled cycle; source is blocked meanwhile.
  logic         prev_ce = 1'b0;
  logic [W-1:0] pa, pb;
  logic         pop;
  always @(negedge clk) begin
    if (rst) begin
      prev_ce = 1'b0;
    end else begin
      if (add_ce) begin
        ce_cycles++;
        if (add_op) ce_op1++;
        chk("exec_s_ready", 32'(s_ready), 32'd0);
        if (prev_ce) begin
          chk("exec_add_a_stable", add_a, pa);
          chk("exec_add_b_stable", add_b, pb);
          chk("exec_add_op_stable", 32'(add_op), 32'(pop));
        end
      end
      prev_ce = add_ce;
      pa = add_a; pb = add_b; pop = add_op;
    end
  end

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send_beat(input logic [31:0] d, input logic last, input logic mode);
    int n = 0;
    s_valid = 1'b1; s_data = d; s_last = last; s_mode = mode;
    while (!s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("beat_timeout", 32'(n), 32'd0);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic get_result(input logic [31:0] exp_d, input int exp_c, input int hold);
    int n = 0;
    while (!m_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("result_timeout", 32'(n), 32'd0);
    chk("m_data", m_data, exp_d);
    chk("m_count", 32'(m_count), 32'(exp_c));
    repeat (hold) begin
      @(negedge clk);
      chk("hold_m_data", m_data, exp_d);
      chk("hold_m_valid", 32'(m_valid), 32'd1);
    end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    chk("m_valid_drop", 32'(m_valid), 32'd0);
  endtask

  task automatic run_vec(input logic [31:0] v[$], input logic mode, input int gap,
                         input int hold);
    for (int i = 0; i < v.size(); i++) begin
      send_beat(v[i], (i == v.size() - 1), (i == 0) ? mode : 1'($urandom));
      repeat (gap) @(negedge clk);
    end
    get_result(ref_reduce(v, mode), v.size(), hold);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v[$];
    int base, base_op, len;
    #3;
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", m_data, 32'd0);
    chk("rst_m_count", 32'(m_count), 32'd0);
    chk("rst_add_ce", 32'(add_ce), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("idle_s_ready", 32'(s_ready), 32'd1);
    @(negedge clk);

    // Sum 1+2+3
    base = ce_cycles;
    v = '{32'h3F800000, 32'h40000000, 32'h40400000};
    run_vec(v, 1'b0, 0, 0);
    chk("sum_value_const", ref_reduce(v, 1'b0), 32'h40C00000);
    chk("sum_ce_cycles", 32'(ce_cycles - base), 32'd4);

    // Difference 3-1-0.5
    base = ce_cycles; base_op = ce_op1;
    v = '{32'h40400000, 32'h3F800000, 32'h3F000000};
    for (int i = 0; i < 3; i++) send_beat(v[i], i == 2, (i == 0) ? 1'b1 : 1'b0);
    get_result(32'h3FC00000, 3, 0);
    chk("diff_ce_cycles", 32'(ce_cycles - base), 32'd4);
    chk("diff_op_sub", 32'(ce_op1 - base_op), 32'd4);

    // Single element passes through with no adder activity
    base = ce_cycles;
    send_beat(32'h40490FDB, 1'b1, 1'b0);
    get_result(32'h40490FDB, 1, 0);
    chk("single_no_ce", 32'(ce_cycles - base), 32'd0);

    // Backpressure with the next vector's first beat waiting
    send_beat(32'h40000000, 1'b0, 1'b0);
    send_beat(32'h40000000, 1'b1, 1'b0);
    for (int n = 0; n < 200 && !m_valid; n++) @(negedge clk);
    s_valid = 1'b1; s_data = 32'h3F000000; s_last = 1'b0; s_mode = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("bp_m_valid", 32'(m_valid), 32'd1);
      chk("bp_m_data", m_data, 32'h40800000);
      chk("bp_m_count", 32'(m_count), 32'd2);
      chk("bp_s_ready", 32'(s_ready), 32'd0);
    end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    chk("bp_one_transfer", 32'(m_valid), 32'd0);
    chk("bp_ready_again", 32'(s_ready), 32'd1);
    send_beat(32'h3F000000, 1'b0, 1'b0);
    send_beat(32'h3E800000, 1'b1, 1'b0);
    get_result(32'h3F400000, 2, 0);

    // Source gaps, difference mode: 1-2-4
    v = '{32'h3F800000, 32'h40000000, 32'h40800000};
    run_vec(v, 1'b1, 2, 3);
    chk("gap_value_const", ref_reduce(v, 1'b1), 32'hC0A00000);

    // Reset in the second EXEC cycle
    send_beat(32'h3F800000, 1'b0, 1'b0);
    send_beat(32'h40000000, 1'b0, 1'b0);
    chk("pre_rst_in_exec", 32'(add_ce), 32'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_s_ready", 32'(s_ready), 32'd0);
    chk("mid_rst_m_valid", 32'(m_valid), 32'd0);
    chk("mid_rst_m_data", m_data, 32'd0);
    chk("mid_rst_m_count", 32'(m_count), 32'd0);
    chk("mid_rst_add_a", add_a, 32'd0);
    chk("mid_rst_add_b", add_b, 32'd0);
    chk("mid_rst_add_op", 32'(add_op), 32'd0);
    chk("mid_rst_add_ce", 32'(add_ce), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    v = '{32'h3F800000, 32'h3F800000};
    run_vec(v, 1'b0, 0, 0);

    // Randomized vectors of exact half-integer values
    repeat (25) begin
      v = {};
      len = int'($urandom_range(1, 5));
      for (int i = 0; i < len; i++) v.push_back(r2sp(real'(int'($urandom_range(0, 64)) - 32) / 2.0));
      run_vec(v, 1'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
